regfile_wb_buffer: RTL
======================

REGFILE_WB_BUFFER -- requirements
Module: regfile_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of write-back buffer entries (power of two, at least 2).
REQ-002 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-003 SHALL have parameter ADDR_W, default 3, meaning register address width (8 registers).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset; one clock, reset is synchronous and active-high.
REQ-006 SHALL have ports ld_valid input 1, ld_addr input ADDR_W, ld_data input DATA_W, ld_ready output 1, meaning the load write-back request channel.
REQ-007 SHALL have ports alu_valid input 1, alu_addr input ADDR_W, alu_data input DATA_W, alu_ready output 1, meaning the ALU write-back request channel.
REQ-008 SHALL have ports wr_en output 1, wr_addr output ADDR_W, wr_data output DATA_W, meaning the register-file write port drive.
REQ-009 SHALL have ports rd_addr_1, rd_addr_2 input ADDR_W, meaning the register-file read addresses being looked up this cycle.
REQ-010 SHALL have ports fwd_hit_1, fwd_hit_2 output 1 and fwd_data_1, fwd_data_2 output DATA_W, meaning pending-write bypass results per read port.

Function
REQ-011 SHALL hold requests in a circular FIFO of DEPTH entries {addr, data}, tracked by head pointer, tail pointer (log2 DEPTH bits, wrapping modulo DEPTH) and count (log2 DEPTH + 1 bits).
REQ-012 SHALL accept a channel transfer on a rising edge where valid and ready are both 1.
REQ-013 SHALL derive ld_ready = (count <= DEPTH-1) from registered count only; same-cycle drain SHALL NOT raise ready.
REQ-014 SHALL derive alu_ready = (count <= DEPTH-2) when ld_valid=1, else (count <= DEPTH-1).
REQ-015 SHALL treat load as older: when both channels transfer in one cycle, the load entry occupies tail and the ALU entry occupies tail+1.
REQ-016 SHALL drive wr_en = (count != 0), with wr_addr/wr_data taken combinationally from the head entry; the register file never back-pressures.
REQ-017 SHALL retire the head entry (head+1, count-1) on every edge where wr_en=1.
REQ-018 SHALL update count as count + accepted (0..2) - retired (0..1) in the same edge; simultaneous enqueue and drain at full or empty SHALL be handled without loss or duplication.
REQ-019 SHALL give minimum latency of one cycle: a request accepted at edge N appears on wr_* in the cycle following edge N.
REQ-020 SHALL drain in strict acceptance order, including two writes to the same address.
REQ-021 SHALL compute fwd_hit_k = 1 when any occupied entry (head entry included) has addr == rd_addr_k, with fwd_data_k taken from the youngest matching entry.
REQ-022 SHALL NOT forward same-cycle incoming ld/alu data; fwd_hit_k = 0 and fwd_data_k = 0 when no match.

Reset
REQ-023 SHALL, while rst=1 at an edge, clear head, tail, count and all entries to 0, discarding any in-flight requests.
REQ-024 SHALL present, in the cycle after reset, wr_en=0, wr_addr=0, wr_data=0, fwd_hit_1/2=0, fwd_data_1/2=0, ld_ready=1, and alu_ready=1 when ld_valid=0.
REQ-025 SHALL treat rst asserted mid-drain as an immediate flush, with no further writes issued.

Structure
REQ-026 SHALL take DATA_W, ADDR_W, NUM_REGS=8 and WB_DEPTH=4 constants and the {addr, data} entry typedef from shared package regfile_pkg.
REQ-027 SHALL place the youngest-match search in one sub-module, wb_fwd_match, instantiated once per read port.

Verification
REQ-028 Single load: ld_addr=3, ld_data=0xDEADBEEF accepted at edge 1 -> wr_en=1, wr_addr=3, wr_data=0xDEADBEEF in cycle 2, wr_en=0 in cycle 3.
REQ-029 Dual issue: ld {2, 0x11} and alu {2, 0x22} in the same cycle -> writes drain {2,0x11} then {2,0x22}; rd_addr_1=2 returns fwd_data_1=0x22 while both are pending.
REQ-030 Full: fill 4 entries with no drain opportunity blocked -> count=4 gives ld_ready=0 and alu_ready=0; with count=3 and both valid -> only load accepted.
REQ-031 Wrap-around: stream 10 alternating requests at 1 per cycle -> pointers wrap, all 10 writes appear in order, with no gaps after the first.
REQ-032 Reset mid-operation: 3 entries pending, rst=1 for one edge -> wr_en=0 and fwd_hit_1/2=0 the next cycle, and no stale write follows.
REQ-033 Forward miss: rd_addr_2=5 with no pending address 5 -> fwd_hit_2=0 and fwd_data_2=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the buffered write-back entry type for the register-file
// write-back buffer.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 8;
   localparam int WB_DEPTH = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the pending write-back entries for one read port.
// Entries arrive in age order: index 0 is the oldest (head), higher is younger.
module wb_fwd_match #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
) (
   input  logic [ADDR_W-1:0]             rd_addr_i,
   input  logic [DEPTH-1:0]              occ_i,
   input  logic [DEPTH-1:0][ADDR_W-1:0]  addr_i,
   input  logic [DEPTH-1:0][DATA_W-1:0]  data_i,
   output logic                          hit_o,
   output logic [DATA_W-1:0]             data_o
);

   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      // Scanning oldest to youngest lets the last match win.
      for (int k = 0; k < DEPTH; k++) begin
         if (occ_i[k] && (addr_i[k] == rd_addr_i)) begin
            hit_o  = 1'b1;
            data_o = data_i[k];
         end
      end
   end

endmodule

// File: rtl/regfile_wb_buffer.sv
// Merges load and ALU write-back requests into an in-order FIFO that drains one
// entry per cycle into the register file, with bypass lookup for two read ports.
module regfile_wb_buffer
   import regfile_pkg::*;
#(
   parameter int DEPTH  = regfile_pkg::WB_DEPTH,
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_1,
   input  logic [ADDR_W-1:0] rd_addr_2,
   output logic              fwd_hit_1,
   output logic [DATA_W-1:0] fwd_data_1,
   output logic              fwd_hit_2,
   output logic [DATA_W-1:0] fwd_data_2
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] alu_slot;
   logic             ld_acc;
   logic             alu_acc;

   wb_entry_t [DEPTH-1:0] entries;

   logic [DEPTH-1:0]             age_occ;
   logic [DEPTH-1:0][ADDR_W-1:0] age_addr;
   logic [DEPTH-1:0][DATA_W-1:0] age_data;

   // Ready looks only at the registered count, so a drain this cycle never helps.
   assign ld_ready  = (count_q <= CNT_W'(DEPTH - 1));
   assign alu_ready = ld_valid ? (count_q <= CNT_W'(DEPTH - 2))
                               : (count_q <= CNT_W'(DEPTH - 1));

   assign ld_acc   = ld_valid & ld_ready;
   assign alu_acc  = alu_valid & alu_ready;
   assign alu_slot = tail_q + PTR_W'(ld_acc);

   assign wr_en   = (count_q != '0);
   assign wr_addr = entries[head_q].addr;
   assign wr_data = entries[head_q].data;

   always_comb begin
      head_d  = head_q + PTR_W'(wr_en);
      tail_d  = tail_q + PTR_W'(ld_acc) + PTR_W'(alu_acc);
      count_d = count_q + CNT_W'(ld_acc) + CNT_W'(alu_acc) - CNT_W'(wr_en);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         wb_entry_t        entry_q;
         logic [PTR_W-1:0] age_slot;

         always_ff @(posedge clk) begin
            if (rst) begin
               entry_q <= '0;
            end else if (alu_acc && (alu_slot == PTR_W'(gi))) begin
               entry_q <= '{addr: alu_addr, data: alu_data};
            end else if (ld_acc && (tail_q == PTR_W'(gi))) begin
               entry_q <= '{addr: ld_addr, data: ld_data};
            end
         end

         assign entries[gi] = entry_q;

         // Rotate storage into age order starting at the head.
         assign age_slot     = head_q + PTR_W'(gi);
         assign age_occ[gi]  = (CNT_W'(gi) < count_q);
         assign age_addr[gi] = entries[age_slot].addr;
         assign age_data[gi] = entries[age_slot].data;
      end
   endgenerate

   wb_fwd_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fwd_1 (
      .rd_addr_i (rd_addr_1),
      .occ_i     (age_occ),
      .addr_i    (age_addr),
      .data_i    (age_data),
      .hit_o     (fwd_hit_1),
      .data_o    (fwd_data_1)
   );

   wb_fwd_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fwd_2 (
      .rd_addr_i (rd_addr_2),
      .occ_i     (age_occ),
      .addr_i    (age_addr),
      .data_i    (age_data),
      .hit_o     (fwd_hit_2),
      .data_o    (fwd_data_2)
   );

endmodule
